stack_tower: RTL and testbench
==============================

Name: stack_tower

Overview:
- Parametrised successor to the single-column catch stack: tracks platform x position, stack height and per-level colours of caught blocks.
- Adds explicit fall-valid qualification, a full/overflow guard, a player pop request, and a match-clear state machine: MATCH_N identical colours on top are removed one level per cycle and scored.
- Sits between the falling-object generator and the VGA renderer.

Parameters:
- DEPTH, 16, maximum stack levels
- COLOR_W, 2, bits per level colour
- BASE_Y, 400, y of the platform top (pixel rows)
- BLOCK_H, 20, pixel height per level
- HIT_MARGIN, 5, pixels above the top surface that still count as a hit
- X_LEEWAY, 15, horizontal hit tolerance (pixels, strict)
- X_RESET, 300, x after reset
- X_MAX, 490, largest x reachable by moving
- DIV_W, 18, movement divider width; one move per 2^DIV_W cycles
- MATCH_N, 3, equal top colours that trigger a clear (2..DEPTH)
- SCORE_W, 8, score width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- pause  in  1  freezes movement only
- left  in  1  move request, +x
- right  in  1  move request, -x
- pop  in  1  remove top level (single-cycle strobe)
- fall_valid  in  1  fall_x/fall_y/fall_color are meaningful
- fall_x  in  10  falling block x
- fall_y  in  10  falling block y (top edge)
- fall_color  in  COLOR_W  falling block colour
- pos_x  out  10  platform x
- pos_y  out  10  current stack top y = BASE_Y - height*BLOCK_H
- height  out  clog2(DEPTH+1)  levels occupied
- colors  out  DEPTH*COLOR_W  level i at bits [i*COLOR_W +: COLOR_W], unoccupied levels are 0
- collision  out  1  one-cycle pulse: block caught, generator must remove it
- overflow  out  1  one-cycle pulse: hit detected while full
- busy  out  1  high in CHECK or CLEAR
- score  out  SCORE_W  cleared matches, saturating

Behaviour:
- Reset (clk edge with rst=1): x=X_RESET, height=0, colors=0, score=0, divider=0, state=IDLE, all pulses 0. Reset overrides every other input, including mid-CLEAR.
- Hit test (combinational; all arithmetic in 12-bit unsigned, no wrap):
  - top = BASE_Y - height*BLOCK_H.
  - y_hit = fall_y + HIT_MARGIN > top and fall_y < top + BLOCK_H.
  - x_hit = fall_x + X_LEEWAY > x and fall_x < x + X_LEEWAY.
  - hit = fall_valid & y_hit & x_hit.
- States:
  - IDLE:
    - hit & height<DEPTH: write fall_color into level height, height+1, collision=1 next cycle, go to CHECK.
    - hit & height==DEPTH: overflow=1, no stack change, stay IDLE.
    - Otherwise pop & height>0: clear top level, height-1.
    - hit has priority over pop in the same cycle; pop on an empty stack is ignored.
  - CHECK (1 cycle):
    - If height>=MATCH_N and levels height-1..height-MATCH_N are all equal: load clear counter = MATCH_N, go to CLEAR.
    - Otherwise go to IDLE.
  - CLEAR:
    - Each cycle zero the top level, height-1, counter-1.
    - When counter reaches 0: score+1 (saturating at 2^SCORE_W-1), go to IDLE.
    - A clear takes exactly MATCH_N cycles.
  - In CHECK and CLEAR: hits and pops are ignored (collision=0, overflow=0), busy=1.
- Movement (independent of state):
  - divider increments every cycle and wraps.
  - When divider==0 and pause=0:
    - left: x+1 if x<X_MAX.
    - Else right: x-1 if x>0.
  - left has priority over right.
- Outputs are registered except pos_y, which is combinational from height.
- collision and overflow last exactly one cycle per event. A fall held over the window while IDLE and the stack is not full can be caught again; the generator clears fall_valid on collision.

Test Plan:
- Reset, then fall_valid=1, fall_x=300, fall_y=398, color=1 -> collision pulse 1 cycle; height=1; colors[1:0]=1; pos_y=380; busy for 1 cycle.
- fall_x=315 (edge) at height 0 with y in window -> no collision; fall_x=314 -> collision. fall_y=395 -> no hit; fall_y=396 -> hit.
- Catch colours 2,2,2 (each after IDLE returns) -> after the third: CHECK, then CLEAR for 3 cycles; height 3->0; colors=0; score=1; hits during busy ignored.
- Fill to DEPTH=16 with alternating colours 1,2 -> height=16; a further hit -> overflow pulse, no collision, colors unchanged.
- height=2, pop strobe -> height=1, level 1 bits zeroed; pop and hit in the same cycle -> hit wins, height increments.
- Hold left with DIV_W reduced to 2, from x=488 -> x increments every 4 cycles, stops at 490; pause=1 freezes x; right from x=1 stops at 0; rst asserted mid-CLEAR -> all reset values on the next edge.

Source files
------------

// File: rtl/stack_tower.sv
// stack_tower: platform position, colour stack with catch/overflow/pop handling and
// a match-clear FSM that removes MATCH_N equal top levels one per cycle and scores them.
module stack_tower #(
   parameter int DEPTH      = 16,
   parameter int COLOR_W    = 2,
   parameter int BASE_Y     = 400,
   parameter int BLOCK_H    = 20,
   parameter int HIT_MARGIN = 5,
   parameter int X_LEEWAY   = 15,
   parameter int X_RESET    = 300,
   parameter int X_MAX      = 490,
   parameter int DIV_W      = 18,
   parameter int MATCH_N    = 3,
   parameter int SCORE_W    = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          pause,
   input  logic                          left,
   input  logic                          right,
   input  logic                          pop,
   input  logic                          fall_valid,
   input  logic [9:0]                    fall_x,
   input  logic [9:0]                    fall_y,
   input  logic [COLOR_W-1:0]            fall_color,
   output logic [9:0]                    pos_x,
   output logic [9:0]                    pos_y,
   output logic [$clog2(DEPTH+1)-1:0]    height,
   output logic [DEPTH*COLOR_W-1:0]      colors,
   output logic                          collision,
   output logic                          overflow,
   output logic                          busy,
   output logic [SCORE_W-1:0]            score
);
   localparam int HW = $clog2(DEPTH+1);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(MATCH_N+1);
   typedef enum logic [1:0] {IDLE, CHECK, CLEAR} state_t;
   state_t state, state_n;
   logic [COLOR_W-1:0] lvl [DEPTH];
   logic [COLOR_W-1:0] lvl_n [DEPTH];
   logic [HW-1:0] height_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [SCORE_W-1:0] score_n;
   logic [DIV_W-1:0] div;
   logic [11:0] top;
   logic [AW-1:0] top_i, base;
   logic hit, match, collision_n, overflow_n;
   // all hit arithmetic is 12-bit so the margins never wrap near the screen edges
   assign top = 12'(BASE_Y) - 12'(height) * 12'(BLOCK_H);
   assign hit = fall_valid
      && (12'(fall_y) + 12'(HIT_MARGIN) > top) && (12'(fall_y) < top + 12'(BLOCK_H))
      && (12'(fall_x) + 12'(X_LEEWAY) > 12'(pos_x)) && (12'(fall_x) < 12'(pos_x) + 12'(X_LEEWAY));
   assign pos_y = 10'(top);
   assign busy  = state != IDLE;
   assign top_i = AW'(height - 1'b1);
   for (genvar i = 0; i < DEPTH; i++) assign colors[i*COLOR_W +: COLOR_W] = lvl[i];
   always_comb begin
      base  = height >= HW'(MATCH_N) ? AW'(height - HW'(MATCH_N)) : '0;
      match = height >= HW'(MATCH_N);
      for (int k = 1; k < MATCH_N; k++)
         if (lvl[base + AW'(k)] != lvl[base]) match = 1'b0;
   end
   always_comb begin
      state_n     = state;
      height_n    = height;
      lvl_n       = lvl;
      cnt_n       = cnt;
      score_n     = score;
      collision_n = 1'b0;
      overflow_n  = 1'b0;
      if (state == IDLE) begin
         if (hit && height < HW'(DEPTH)) begin
            lvl_n[AW'(height)] = fall_color;
            height_n    = height + 1'b1;
            collision_n = 1'b1;
            state_n     = CHECK;
         end else if (hit) overflow_n = 1'b1;
         else if (pop && height != '0) begin
            lvl_n[top_i] = '0;
            height_n     = height - 1'b1;
         end
      end else if (state == CHECK) begin
         state_n = match ? CLEAR : IDLE;
         cnt_n   = CW'(MATCH_N);
      end else begin
         lvl_n[top_i] = '0;
         height_n     = height - 1'b1;
         cnt_n        = cnt - 1'b1;
         state_n      = cnt == CW'(1) ? IDLE : CLEAR;
         score_n      = cnt == CW'(1) && !(&score) ? score + 1'b1 : score;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         height    <= '0;
         lvl       <= '{default: '0};
         cnt       <= '0;
         score     <= '0;
         collision <= 1'b0;
         overflow  <= 1'b0;
         div       <= '0;
         pos_x     <= 10'(X_RESET);
      end else begin
         state     <= state_n;
         height    <= height_n;
         lvl       <= lvl_n;
         cnt       <= cnt_n;
         score     <= score_n;
         collision <= collision_n;
         overflow  <= overflow_n;
         div       <= div + 1'b1;
         if (div == '0 && !pause)
            pos_x <= left ? (pos_x < 10'(X_MAX) ? pos_x + 1'b1 : pos_x)
                   : (right && pos_x != '0) ? pos_x - 1'b1 : pos_x;
      end
   end
endmodule

// File: tb/tb_stack_tower.sv
// tb_stack_tower: directed vectors with hand-computed expectations for stack_tower.
module tb_stack_tower;
   logic clk = 1'b0, rst, pause, left, right, pop, fall_valid;
   logic [9:0] fall_x, fall_y, pos_x, pos_y;
   logic [1:0] fall_color;
   logic [4:0] height;
   logic [31:0] colors;
   logic collision, overflow, busy;
   logic [7:0] score;
   int n_chk = 0, n_fail = 0;

   stack_tower #(.DIV_W(2)) dut (
      .clk(clk), .rst(rst), .pause(pause), .left(left), .right(right), .pop(pop),
      .fall_valid(fall_valid), .fall_x(fall_x), .fall_y(fall_y), .fall_color(fall_color),
      .pos_x(pos_x), .pos_y(pos_y), .height(height), .colors(colors),
      .collision(collision), .overflow(overflow), .busy(busy), .score(score)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic reset_dut;
      rst = 1'b1;
      tick;
      rst = 1'b0;
   endtask

   task automatic drop(input logic [9:0] fx, input logic [9:0] fy, input logic [1:0] c);
      fall_x = fx;
      fall_y = fy;
      fall_color = c;
      fall_valid = 1'b1;
      tick;
      fall_valid = 1'b0;
   endtask

   initial begin
      {rst, pause, left, right, pop, fall_valid} = '0;
      fall_x = '0;
      fall_y = '0;
      fall_color = '0;
      reset_dut;
      check("rst_x", pos_x, 300);
      check("rst_h", height, 0);
      check("rst_y", pos_y, 400);
      check("rst_col", colors, 0);
      check("rst_score", score, 0);
      check("rst_busy", busy, 0);
      check("rst_coll", collision, 0);
      check("rst_ovf", overflow, 0);
      // first catch
      drop(300, 398, 1);
      check("c1_coll", collision, 1);
      check("c1_h", height, 1);
      check("c1_busy", busy, 1);
      check("c1_col", colors, 1);
      check("c1_y", pos_y, 380);
      tick;
      check("c1_coll_end", collision, 0);
      check("c1_busy_end", busy, 0);
      // hit window edges at height 0
      reset_dut;
      drop(315, 398, 1);
      check("x315", collision, 0);
      check("x315_h", height, 0);
      drop(314, 398, 1);
      check("x314", collision, 1);
      reset_dut;
      drop(300, 395, 1);
      check("y395", collision, 0);
      drop(300, 396, 1);
      check("y396", collision, 1);
      // fill with alternating colours, then overflow
      reset_dut;
      for (int i = 0; i < 16; i++) begin
         drop(300, 10'(398 - 20 * i), (i % 2) ? 2'd2 : 2'd1);
         tick;
      end
      check("full_h", height, 16);
      check("full_col", colors, 32'h9999_9999);
      check("full_y", pos_y, 80);
      drop(300, 78, 3);
      check("ovf", overflow, 1);
      check("ovf_coll", collision, 0);
      check("ovf_h", height, 16);
      check("ovf_col", colors, 32'h9999_9999);
      tick;
      check("ovf_end", overflow, 0);
      // pop and pop-vs-hit priority
      reset_dut;
      drop(300, 398, 1);
      tick;
      drop(300, 378, 2);
      tick;
      check("pre_pop_col", colors, 32'h9);
      pop = 1'b1;
      tick;
      pop = 1'b0;
      check("pop_h", height, 1);
      check("pop_col", colors, 32'h1);
      pop = 1'b1;
      drop(300, 378, 3);
      pop = 1'b0;
      check("pophit_h", height, 2);
      check("pophit_coll", collision, 1);
      check("pophit_col", colors, 32'hD);
      tick;
      reset_dut;
      pop = 1'b1;
      tick;
      pop = 1'b0;
      check("pop_empty", height, 0);
      // three equal colours clear
      reset_dut;
      drop(300, 398, 2);
      tick;
      drop(300, 378, 2);
      tick;
      drop(300, 358, 2);
      check("m_h3", height, 3);
      tick;
      check("m_busy", busy, 1);
      check("m_h3b", height, 3);
      fall_x = 300;
      fall_y = 338;
      fall_color = 1;
      fall_valid = 1'b1;
      tick;
      fall_valid = 1'b0;
      check("m_ignored", collision, 0);
      check("m_h2", height, 2);
      check("m_col2", colors, 32'hA);
      tick;
      check("m_h1", height, 1);
      tick;
      check("m_h0", height, 0);
      check("m_col0", colors, 0);
      check("m_score", score, 1);
      check("m_idle", busy, 0);
      // movement
      left = 1'b1;
      for (int i = 0; i < 2000 && pos_x != 488; i++) tick;
      check("mv_488", pos_x, 488);
      repeat (3) tick;
      check("mv_hold", pos_x, 488);
      tick;
      check("mv_489", pos_x, 489);
      repeat (4) tick;
      check("mv_490", pos_x, 490);
      repeat (8) tick;
      check("mv_max", pos_x, 490);
      left = 1'b0;
      right = 1'b1;
      pause = 1'b1;
      repeat (8) tick;
      check("mv_pause", pos_x, 490);
      pause = 1'b0;
      for (int i = 0; i < 3000 && pos_x != 1; i++) tick;
      check("mv_1", pos_x, 1);
      repeat (4) tick;
      check("mv_0", pos_x, 0);
      repeat (8) tick;
      check("mv_min", pos_x, 0);
      right = 1'b0;
      // reset in the middle of a clear
      drop(0, 398, 2);
      tick;
      drop(0, 378, 2);
      tick;
      drop(0, 358, 2);
      tick;
      tick;
      check("rc_busy", busy, 1);
      check("rc_h", height, 2);
      reset_dut;
      check("rc_h0", height, 0);
      check("rc_col", colors, 0);
      check("rc_score", score, 0);
      check("rc_idle", busy, 0);
      check("rc_x", pos_x, 300);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
